comp_seq_ctrl: RTL

//  Sequencer that reuses one 4-bit equal/greater/less slice comparator to compare wide

---
 rtl/comp_seq_ctrl_pkg.sv | 14 +
 rtl/comp_slice4.sv | 23 ++
 rtl/comp_seq_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/comp_seq_ctrl_pkg.sv
// Shared definitions for the slice-sequenced comparator.
//   SLICE_W : width of one comparator slice
//   state_t : controller state encoding (2'd3 is unused and recovers to IDLE)
package comp_seq_ctrl_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/comp_slice4.sv
// Combinational 4-bit unsigned equal/greater/less slice comparator.
// Ports:
//   i_a, i_b : slice operands (unsigned)
//   o_eq     : i_a == i_b
//   o_gt     : i_a >  i_b
//   o_lt     : i_a <  i_b
module comp_slice4
    import comp_seq_ctrl_pkg::*;
(
    input  logic [SLICE_W-1:0] i_a,
    input  logic [SLICE_W-1:0] i_b,
    output logic               o_eq,
    output logic               o_gt,
    output logic               o_lt
);

    always_comb begin
        o_eq = (i_a == i_b);
        o_gt = (i_a >  i_b);
        o_lt = (i_a <  i_b);
    end

endmodule

// File: rtl/comp_seq_ctrl.sv
// Wide unsigned comparator built from one 4-bit slice comparator. Operands are
// registered on the start handshake, then walked MSB slice first, one slice per
// cycle, stopping at the first unequal slice.
// Ports:
//   clk, rst_n               : clock, synchronous active-low reset
//   start_valid/start_ready  : operand handshake (a, b sampled on accept)
//   a, b                     : DATA_W-bit unsigned operands
//   res_valid/res_ready      : result handshake
//   eq, gt, lt               : one-hot compare result while res_valid
//   cycles                   : number of slices evaluated (1..NSLICE)
module comp_seq_ctrl
    import comp_seq_ctrl_pkg::*;
#(
    parameter  int DATA_W = 16,
    localparam int NSLICE = DATA_W / SLICE_W,
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              eq,
    output logic              gt,
    output logic              lt,
    output logic [IDX_W:0]    cycles
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_a_q;
    logic [DATA_W-1:0]   r_b_q;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W:0]      r_cnt;
    logic                r_eq;
    logic                r_gt;
    logic                r_lt;

    logic [SLICE_W-1:0]  w_a_slice;
    logic [SLICE_W-1:0]  w_b_slice;
    logic                w_slice_eq;
    logic                w_slice_gt;
    logic                w_slice_lt;
    logic                w_accept;
    logic                w_last;

    // Only the currently indexed slice reaches the shared comparator.
    assign w_a_slice = r_a_q[r_idx*SLICE_W +: SLICE_W];
    assign w_b_slice = r_b_q[r_idx*SLICE_W +: SLICE_W];
    assign w_last    = (r_idx == '0);

    comp_slice4 u_slice (
        .i_a  (w_a_slice),
        .i_b  (w_b_slice),
        .o_eq (w_slice_eq),
        .o_gt (w_slice_gt),
        .o_lt (w_slice_lt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        // start_ready is gated by rst_n so nothing is accepted during reset.
        start_ready = rst_n && (r_state == IDLE);
        res_valid   = (r_state == DONE);
        w_accept    = start_valid && start_ready;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (!w_slice_eq || w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Operands are pure data: no reset; a reset simply prevents them from being used.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a_q <= a;
            r_b_q <= b;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx <= '0;
            r_cnt <= '0;
            r_eq  <= 1'b0;
            r_gt  <= 1'b0;
            r_lt  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_idx <= IDX_W'(NSLICE - 1);
                        r_cnt <= '0;
                    end
                end
                RUN: begin
                    r_cnt <= r_cnt + (IDX_W+1)'(1);
                    if (!w_slice_eq) begin
                        r_gt <= w_slice_gt;
                        r_lt <= w_slice_lt;
                    end else if (w_last) begin
                        r_eq <= 1'b1;
                    end else begin
                        r_idx <= r_idx - IDX_W'(1);
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        r_eq <= 1'b0;
                        r_gt <= 1'b0;
                        r_lt <= 1'b0;
                    end
                end
                default: begin
                    r_eq <= 1'b0;
                    r_gt <= 1'b0;
                    r_lt <= 1'b0;
                end
            endcase
        end
    end

    assign eq     = r_eq;
    assign gt     = r_gt;
    assign lt     = r_lt;
    assign cycles = r_cnt;

endmodule
